// File: rtl/adc_chan_sched_if.sv
// Scheduler <-> ADC front end / sample consumer bundle.
// master: the scheduler side; slave: the converter, host controls and averaging stage.
interface adc_chan_sched_if #(
    parameter int NCH       = 4,
    parameter int CH_NBIT   = 2,
    parameter int DATA_NBIT = 12
);
    logic                 i_enable;
    logic [NCH-1:0]       i_ch_mask;
    logic [CH_NBIT-1:0]   o_mux_sel;
    logic                 o_conv_start;
    logic                 i_conv_done;
    logic [DATA_NBIT-1:0] i_conv_data;
    logic                 o_strobe;
    logic [CH_NBIT-1:0]   o_ch;
    logic [DATA_NBIT-1:0] o_data;
    logic                 o_timeout_err;
    logic                 o_busy;

    modport master (
        input  i_enable, i_ch_mask, i_conv_done, i_conv_data,
        output o_mux_sel, o_conv_start, o_strobe, o_ch, o_data, o_timeout_err, o_busy
    );

    modport slave (
        output i_enable, i_ch_mask, i_conv_done, i_conv_data,
        input  o_mux_sel, o_conv_start, o_strobe, o_ch, o_data, o_timeout_err, o_busy
    );
endinterface

// File: rtl/adc_chan_sched.sv
// Round-robin scheduler sharing one ADC between NCH channels: select, settle, start, wait (with timeout).
// Start lands SETTLE+2 cycles after enable; sample strobe one cycle after done.
module adc_chan_sched #(
    parameter int NCH       = 4,
    parameter int CH_NBIT   = 2,
    parameter int DATA_NBIT = 12,
    parameter int SETTLE    = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst,
    adc_chan_sched_if.master bus
);
    localparam int SNB = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TNB = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_SETTLE = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4
    } state_t;

    state_t               state_q,   state_d;
    logic [CH_NBIT-1:0]   mux_sel_q, mux_sel_d;
    logic [CH_NBIT-1:0]   last_ch_q, last_ch_d;
    logic [SNB-1:0]       settle_q,  settle_d;
    logic [TNB-1:0]       tmo_q,     tmo_d;
    logic                 strobe_q,  strobe_d;
    logic [CH_NBIT-1:0]   ch_q,      ch_d;
    logic [DATA_NBIT-1:0] data_q,    data_d;
    logic                 err_q,     err_d;

    logic [CH_NBIT-1:0]   next_ch;
    logic                 next_found;
    logic [CH_NBIT-1:0]   probe_ch;
    logic                 scan_ok;

    assign scan_ok = bus.i_enable && (|bus.i_ch_mask);

    // Search starts one past the last served channel, so the last one is only reused when it is alone.
    always_comb begin
        next_ch    = last_ch_q;
        next_found = 1'b0;
        probe_ch   = last_ch_q;
        for (int k = 1; k <= NCH; k++) begin
            probe_ch = CH_NBIT'((int'(last_ch_q) + k) % NCH);
            if (!next_found && bus.i_ch_mask[probe_ch]) begin
                next_ch    = probe_ch;
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mux_sel_d = mux_sel_q;
        last_ch_d = last_ch_q;
        settle_d  = settle_q;
        tmo_d     = tmo_q;
        strobe_d  = 1'b0;
        ch_d      = ch_q;
        data_d    = data_q;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (scan_ok) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (next_found) begin
                    mux_sel_d = next_ch;
                    last_ch_d = next_ch;
                    settle_d  = SNB'(SETTLE - 1);
                    state_d   = ST_SETTLE;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_START;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            ST_START: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Done is checked first so a last-cycle completion is never reported as a timeout.
                if (bus.i_conv_done) begin
                    data_d   = bus.i_conv_data;
                    ch_d     = mux_sel_q;
                    strobe_d = 1'b1;
                    state_d  = scan_ok ? ST_SELECT : ST_IDLE;
                end else if (tmo_q == TNB'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    state_d  = scan_ok ? ST_SELECT : ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mux_sel_q <= '0;
            last_ch_q <= CH_NBIT'(NCH - 1);
            settle_q  <= '0;
            tmo_q     <= '0;
            strobe_q  <= 1'b0;
            ch_q      <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mux_sel_q <= mux_sel_d;
            last_ch_q <= last_ch_d;
            settle_q  <= settle_d;
            tmo_q     <= tmo_d;
            strobe_q  <= strobe_d;
            ch_q      <= ch_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    assign bus.o_mux_sel     = mux_sel_q;
    assign bus.o_conv_start  = (state_q == ST_START);
    assign bus.o_strobe      = strobe_q;
    assign bus.o_ch          = ch_q;
    assign bus.o_data        = data_q;
    assign bus.o_timeout_err = err_q;
    assign bus.o_busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_adc_chan_sched.sv
// Bench for adc_chan_sched: transaction-level round-robin/latency model with a randomized converter responder.
module tb_adc_chan_sched;
    localparam int NCH       = 4;
    localparam int CH_NBIT   = 2;
    localparam int DATA_NBIT = 12;
    localparam int SETTLE    = 4;
    localparam int TIMEOUT   = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adc_chan_sched_if #(.NCH(NCH), .CH_NBIT(CH_NBIT), .DATA_NBIT(DATA_NBIT)) bus ();

    adc_chan_sched #(
        .NCH(NCH), .CH_NBIT(CH_NBIT), .DATA_NBIT(DATA_NBIT),
        .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_chk = 0;
    int n_err = 0;
    int last_ch;
    logic [DATA_NBIT-1:0] exp_data;
    logic [CH_NBIT-1:0]   exp_ch;
    bit fixed_data;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_next(input int last, input logic [NCH-1:0] mask);
        for (int k = 1; k <= NCH; k++) begin
            if (mask[(last + k) % NCH]) return (last + k) % NCH;
        end
        return -1;
    endfunction

    task automatic chk_reset_outs(input string tag);
        chk_eq({tag, "_mux"},    32'(bus.o_mux_sel), 0);
        chk_eq({tag, "_start"},  32'(bus.o_conv_start), 0);
        chk_eq({tag, "_strobe"}, 32'(bus.o_strobe), 0);
        chk_eq({tag, "_ch"},     32'(bus.o_ch), 0);
        chk_eq({tag, "_data"},   32'(bus.o_data), 0);
        chk_eq({tag, "_err"},    32'(bus.o_timeout_err), 0);
        chk_eq({tag, "_busy"},   32'(bus.o_busy), 0);
    endtask

    // Counts cycles until the start pulse is visible; exp_gap < 0 skips the latency comparison.
    task automatic wait_start(input int exp_gap);
        int n = 0;
        while (!bus.o_conv_start && n < 64) begin
            step();
            n++;
        end
        if (!bus.o_conv_start) chk_eq("start_seen", 0, 1);
        else if (exp_gap >= 0) chk_eq("start_gap", n, exp_gap);
    endtask

    // Called in the start-pulse cycle. dly = cycles after start at which done is driven (0 = never).
    task automatic conv(input int dly, input bit drop_en);
        int ch;
        logic [DATA_NBIT-1:0] d;
        ch = rr_next(last_ch, bus.i_ch_mask);
        chk_eq("rr_ch", 32'(bus.o_mux_sel), 32'(ch));
        chk_eq("busy_conv", 32'(bus.o_busy), 1);
        last_ch = ch;
        d = fixed_data ? DATA_NBIT'(ch * 'h100 + 1) : DATA_NBIT'($urandom);
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            step();
            bus.i_conv_done = 1'b0;
            if (k == 1) chk_eq("start_1cyc", 32'(bus.o_conv_start), 0);
            if (dly != 0 && k == dly + 1) begin
                exp_data = d;
                exp_ch   = CH_NBIT'(ch);
                chk_eq("strobe", 32'(bus.o_strobe), 1);
                chk_eq("strobe_err", 32'(bus.o_timeout_err), 0);
                chk_eq("o_ch", 32'(bus.o_ch), 32'(exp_ch));
                chk_eq("o_data", 32'(bus.o_data), 32'(exp_data));
                break;
            end
            if (dly == 0 && k == TIMEOUT + 1) begin
                chk_eq("tmo_err", 32'(bus.o_timeout_err), 1);
                chk_eq("tmo_nostrobe", 32'(bus.o_strobe), 0);
                chk_eq("tmo_data_held", 32'(bus.o_data), 32'(exp_data));
                break;
            end
            chk_eq("quiet", 32'(bus.o_strobe | bus.o_timeout_err), 0);
            chk_eq("mux_stable", 32'(bus.o_mux_sel), 32'(ch));
            if (drop_en && k == 1) bus.i_enable = 1'b0;
            if (dly != 0 && k == dly) begin
                bus.i_conv_done = 1'b1;
                bus.i_conv_data = d;
            end
        end
        chk_eq("busy_exit", 32'(bus.o_busy), 32'(bus.i_enable && (|bus.i_ch_mask)));
    endtask

    initial begin
        rst = 1'b1;
        bus.i_enable    = 1'b0;
        bus.i_ch_mask   = '0;
        bus.i_conv_done = 1'b0;
        bus.i_conv_data = '0;
        last_ch    = NCH - 1;
        exp_data   = '0;
        exp_ch     = '0;
        fixed_data = 1'b1;
        repeat (3) step();
        chk_reset_outs("rst0");
        rst = 1'b0;
        step();

        // All four channels, done 3 cycles after each start, tagged data.
        bus.i_ch_mask = 4'b1111;
        bus.i_enable  = 1'b1;
        wait_start(SETTLE + 2);
        for (int i = 0; i < 5; i++) begin
            conv(3, 1'b0);
            wait_start(SETTLE + 1);
        end
        fixed_data = 1'b0;

        // Sparse masks and wrap-around; mask changed during the SELECT cycle.
        conv(2, 1'b0);
        bus.i_ch_mask = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            wait_start(SETTLE + 1);
            conv($urandom_range(1, TIMEOUT), 1'b0);
        end
        bus.i_ch_mask = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            wait_start(SETTLE + 1);
            conv($urandom_range(1, 6), 1'b0);
        end
        bus.i_ch_mask = '0;
        step();
        chk_eq("mask0_busy", 32'(bus.o_busy), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_eq("mask0_idle", 32'(bus.o_busy | bus.o_conv_start), 0);
        end

        // Timeout, then the scan proceeds; then done on the last permitted cycle.
        bus.i_ch_mask = 4'b0011;
        wait_start(SETTLE + 2);
        conv(0, 1'b0);
        wait_start(SETTLE + 1);
        conv(TIMEOUT, 1'b0);
        wait_start(SETTLE + 1);
        conv(1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            int dsel;
            if ($urandom_range(0, 3) == 0) bus.i_ch_mask = 4'($urandom_range(1, 15));
            wait_start(SETTLE + 1);
            dsel = $urandom_range(0, 4) == 0 ? 0 : $urandom_range(1, TIMEOUT);
            conv(dsel, 1'b0);
        end

        // Enable drops while ch2 is converting: sample still delivered, then IDLE ignores done.
        bus.i_ch_mask = 4'b0100;
        wait_start(SETTLE + 1);
        conv(5, 1'b1);
        step();
        bus.i_conv_done = 1'b1;
        bus.i_conv_data = DATA_NBIT'(12'hABC);
        step();
        bus.i_conv_done = 1'b0;
        chk_eq("idle_done_nostrobe", 32'(bus.o_strobe), 0);
        chk_eq("idle_data_held", 32'(bus.o_data), 32'(exp_data));
        chk_eq("idle_ch_held", 32'(bus.o_ch), 32'(exp_ch));
        chk_eq("idle_busy", 32'(bus.o_busy), 0);

        // Reset during WAIT with a done pending.
        bus.i_ch_mask = 4'b1110;
        bus.i_enable  = 1'b1;
        wait_start(SETTLE + 2);
        step();
        step();
        rst = 1'b1;
        bus.i_conv_done = 1'b1;
        bus.i_conv_data = DATA_NBIT'(12'h5A5);
        step();
        bus.i_conv_done = 1'b0;
        chk_reset_outs("rst_wait");
        last_ch  = NCH - 1;
        exp_data = '0;
        rst = 1'b0;
        wait_start(SETTLE + 2);
        conv(4, 1'b0);

        // Reset during SETTLE.
        step();
        step();
        rst = 1'b1;
        step();
        chk_reset_outs("rst_settle");
        last_ch = NCH - 1;
        rst = 1'b0;
        wait_start(SETTLE + 2);
        conv(2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
